// File: rtl/fifo_pkg.sv
// fifo_pkg: shared defaults, read-side FSM states and output buffer depth
package fifo_pkg;
    localparam int FIFO_WIDTH = 16;
    localparam int FIFO_DEPTH = 8;
    localparam int RD_BUF_DEPTH = 3;
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} rd_state_t;
endpackage

// File: rtl/fifo_stream_reader_if.sv
// fifo_stream_reader_if: FIFO read port plus downstream valid/ready stream
interface fifo_stream_reader_if #(parameter int FIFO_WIDTH = 16);
    logic                  rd_en;
    logic [FIFO_WIDTH-1:0] data_out;
    logic                  empty;
    logic                  underflow;
    logic                  m_valid;
    logic [FIFO_WIDTH-1:0] m_data;
    logic                  m_ready;
    modport master (output rd_en, m_valid, m_data, input data_out, empty, underflow, m_ready);
    modport slave (input rd_en, m_valid, m_data, output data_out, empty, underflow, m_ready);
endinterface

// File: rtl/fifo_rd_skid.sv
// fifo_rd_skid: 3-entry in-order register buffer, head always in entry 0
module fifo_rd_skid
    import fifo_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [1:0]       occ_o,
    output logic [WIDTH-1:0] head_o
);
    logic [WIDTH-1:0] mem_q [RD_BUF_DEPTH];
    logic [1:0]       occ_q, occ_d, wr_idx;
    always_comb begin
        wr_idx = occ_q - {1'b0, pop_i};
        occ_d  = occ_q + {1'b0, push_i} - {1'b0, pop_i};
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q <= '{default: '0};
            occ_q <= '0;
        end else begin
            assert (!(push_i && !pop_i && occ_q == 2'(RD_BUF_DEPTH)));
            if (pop_i) begin
                mem_q[0] <= mem_q[1];
                mem_q[1] <= mem_q[2];
                mem_q[2] <= '0;
            end
            // issued after the shift so a simultaneous push lands behind the survivors
            if (push_i) mem_q[wr_idx] <= push_data_i;
            occ_q <= occ_d;
        end
    end
    assign occ_o  = occ_q;
    assign head_o = mem_q[0];
endmodule

// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader: credit-based FIFO read controller feeding a valid/ready stream
module fifo_stream_reader #(
    parameter int FIFO_WIDTH = fifo_pkg::FIFO_WIDTH,
    parameter int CNT_W      = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en_i,
    fifo_stream_reader_if.master bus,
    output logic                 busy_o,
    output logic                 underflow_err_o,
    output logic [CNT_W-1:0]     rd_count_o
);
    import fifo_pkg::*;
    rd_state_t        state_q, state_d;
    logic             inflight_q, underflow_err_q, pop;
    logic [1:0]       occ;
    logic [CNT_W-1:0] rd_count_q, rd_count_d;
    fifo_rd_skid #(.WIDTH(FIFO_WIDTH)) u_skid (
        .clk         (clk),
        .rst         (rst),
        .push_i      (inflight_q),
        .push_data_i (bus.data_out),
        .pop_i       (pop),
        .occ_o       (occ),
        .head_o      (bus.m_data)
    );
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = en_i ? RUN : IDLE;
            RUN:     state_d = en_i ? RUN : DRAIN;
            DRAIN:   state_d = en_i ? RUN : (occ == 2'd0 && !inflight_q) ? IDLE : DRAIN;
            default: state_d = IDLE;
        endcase
        // credit uses only registered occupancy, keeping m_ready off the rd_en path
        bus.rd_en   = state_q == RUN && !bus.empty
                      && ({1'b0, occ} + {2'b0, inflight_q} < 3'(RD_BUF_DEPTH));
        bus.m_valid = occ != 2'd0;
        pop         = occ != 2'd0 && bus.m_ready;
        rd_count_d  = rd_count_q + CNT_W'(pop);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= IDLE;
            inflight_q      <= 1'b0;
            underflow_err_q <= 1'b0;
            rd_count_q      <= '0;
        end else begin
            state_q         <= state_d;
            inflight_q      <= bus.rd_en;
            underflow_err_q <= underflow_err_q | bus.underflow;
            rd_count_q      <= rd_count_d;
        end
    end
    assign busy_o          = state_q != IDLE;
    assign underflow_err_o = underflow_err_q;
    assign rd_count_o      = rd_count_q;
endmodule

// File: doc/fifo_stream_reader.md
# fifo_stream_reader

Read-side controller for the team's synchronous FIFO. It issues `rd_en` from the FIFO's `empty` flag, captures `data_out` one cycle later into a 3-entry output buffer, and presents the words downstream as a valid/ready stream at full throughput with no combinational path from `m_ready` to `rd_en`. It also reports FIFO underflow and counts delivered words.

## Interface
- `FIFO_WIDTH`, 16, data width; must match the FIFO instance.
- `CNT_W`, 16, width of the delivered-word counter.
- `clk  in  1`  system clock; all logic on its rising edge.
- `rst  in  1`  reset, synchronous, active-high.
- `en  in  1`  run enable; low stops new FIFO reads.
- `rd_en  out  1`  FIFO read request.
- `data_out  in  FIFO_WIDTH`  FIFO read data, valid the cycle after an accepted read.
- `empty  in  1`  FIFO empty flag.
- `underflow  in  1`  FIFO underflow flag, registered by the FIFO.
- `m_valid  out  1`  downstream data valid.
- `m_data  out  FIFO_WIDTH`  downstream data, the buffer head.
- `m_ready  in  1`  downstream ready.
- `busy  out  1`  state is not IDLE.
- `underflow_err  out  1`  sticky underflow indication.
- `rd_count  out  CNT_W`  count of words delivered downstream.

## Operation
- **Reset values:** all outputs 0, state IDLE, `occ` = 0, `inflight` = 0, buffer contents 0.
- **Accepted read:** `rd_en` is high on a rising edge and `empty` is low. The FIFO then presents the word on `data_out` in the next cycle.
- **`inflight`:** a register set by an accepted read. In the following cycle the block writes `data_out` into the buffer tail and clears `inflight` unless another read is accepted in that cycle.
- **Buffer:** 3 entries, in-order. `occ` ranges 0..3. `m_valid` = (`occ` != 0). `m_data` = head entry.
- **Pop:** `m_valid` && `m_ready`. When a pop and a push happen in the same cycle, `occ` is unchanged.
- **Read issue:** `rd_en` = (state == RUN) && !`empty` && (`occ` + `inflight` < 3). The operands are registered state, so there is no dependence on `m_ready`.
- **No overrun:** the credit rule guarantees `occ` never exceeds 3. An overrun is an RTL bug; flag it with an assertion.
- **FSM:**
  - IDLE -> RUN when `en`.
  - RUN -> DRAIN when !`en`.
  - DRAIN -> RUN when `en`.
  - DRAIN -> IDLE when `occ` == 0 && !`inflight` && !`en`.
- **Draining:** in IDLE and DRAIN, `rd_en` = 0 but buffered and in-flight words are still delivered.
- **`underflow_err`:** set on any cycle with `underflow` = 1; cleared only by `rst`.
- **`rd_count`:** increments by 1 on each pop and wraps modulo 2^`CNT_W`.
- **`busy`:** 1 in RUN and DRAIN.

## Timing
- **FIFO to downstream latency:**
  - Read accepted at edge N -> word enters the buffer at edge N+1.
  - `m_valid` is high after edge N+1 when the buffer was empty.
  - Minimum 2 cycles from `empty` falling to `m_valid` rising.
- **Throughput:** 1 word per cycle with `m_ready` held high and the FIFO not empty. Steady state is `occ` = 1, `inflight` = 1.
- **Backpressure:** with `m_ready` low, at most 3 words are held. `rd_en` drops once `occ` + `inflight` = 3.
- **Held data:** `m_data` is stable while `m_valid` && !`m_ready`.
- **`empty` rising:** `rd_en` falls in the same cycle (combinational from `empty`). No further reads are issued.
- **`en` falls with a read in flight:** that word is still captured and delivered.
- **`rst` mid-operation:** buffer and in-flight words are discarded. Takes effect on the edge `rst` is sampled.
- **Counter at all-ones:** `rd_count` wraps to 0 on the next pop.

## Structure
- **Package `fifo_pkg`:**
  - `FIFO_WIDTH` / `FIFO_DEPTH` defaults (16/8).
  - `rd_state_t` enum {IDLE, RUN, DRAIN}.
  - localparam `RD_BUF_DEPTH` = 3.
- **Sub-module `fifo_rd_skid`:**
  - 3-entry register buffer with `push`, `push_data`, `pop`, `occ`, `head`.
  - The top level holds the FSM, credit logic, `inflight`, flags and counter.

## Test plan
- **Reset:** hold `rst` 2 cycles with FIFO non-empty and `en` = 1 -> all outputs 0 during reset; first `rd_en` on the cycle after `rst` falls once state is RUN.
- **Streaming:** write 8 words 0x0001..0x0008 into the FIFO, `en` = 1, `m_ready` = 1 -> `m_data` 0x0001..0x0008 in order on 8 consecutive cycles, then `rd_count` = 8.
- **Backpressure:** FIFO holds 8 words, `m_ready` = 0 -> exactly 3 reads issued, `rd_en` then stays 0, `m_data` holds 0x0001; raise `m_ready` -> all 8 words delivered in order, none lost or duplicated.
- **Drain:** deassert `en` the cycle after a read is accepted with `occ` = 2 -> 3 words still delivered, no further `rd_en`, `busy` falls after the last pop.
- **Underflow:** force `underflow` = 1 for one cycle -> `underflow_err` = 1 and stays 1 until `rst`.
- **Empty and wrap:** `empty` = 1 throughout -> `rd_en` never asserts. Preload `rd_count` at 0xFFFF via force -> one pop gives 0x0000.
